// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths and result record for the writeback arbiter
package wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int REC_W      = REG_ADDR_W + XLEN;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'b00000;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic [XLEN-1:0]       data;
    } wb_rec_t;

    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] a);
        return a == REG_ZERO;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - result sources, scoreboard and regfile write port bundle
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_dst;
    logic [XLEN-1:0]       alu_data;
    logic                  alu_stall;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [REG_ADDR_W-1:0] lsu_dst;
    logic [XLEN-1:0]       lsu_data;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_dst;
    logic [31:0]           busy;
    logic                  write_reg;
    logic [REG_ADDR_W-1:0] dstreg_addr;
    logic [XLEN-1:0]       dstreg_data;

    modport slave (
        input  alu_valid, alu_dst, alu_data, lsu_valid, lsu_dst, lsu_data,
               issue_valid, issue_dst,
        output alu_stall, lsu_ready, busy, write_reg, dstreg_addr, dstreg_data
    );

    modport master (
        output alu_valid, alu_dst, alu_data, lsu_valid, lsu_dst, lsu_data,
               issue_valid, issue_dst,
        input  alu_stall, lsu_ready, busy, write_reg, dstreg_addr, dstreg_data
    );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small LSU result FIFO, head visible without a pop
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign head_o  = mem[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_i) wr_d = wr_q + PTR_ONE;
        if (pop_i)  rd_d = rd_q + PTR_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges ALU and LSU results onto the regfile write port
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.slave   wb
);

    localparam int CW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_LIMIT - 1);

    logic    full, empty, push, grant_lsu, grant_alu;
    wb_rec_t head, in_rec;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  stall_q, stall_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic [31:0]           busy_q, busy_d;

    assign in_rec.dst  = wb.lsu_dst;
    assign in_rec.data = wb.lsu_data;

    // lsu_ready depends only on FIFO state, never on lsu_valid.
    assign push      = wb.lsu_valid && !full;
    assign grant_lsu = !empty && (stall_q || !wb.alu_valid);
    assign grant_alu = wb.alu_valid && !grant_lsu;

    wb_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (in_rec),
        .pop_i   (grant_lsu),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    always_comb begin
        cnt_d   = cnt_q;
        stall_d = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;

        if (grant_alu && !empty) begin
            if (cnt_q == CNT_LAST) begin
                stall_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end

        if (grant_lsu) begin
            we_d   = !is_zero_reg(head.dst);
            addr_d = head.dst;
            data_d = head.data;
            busy_d[head.dst] = 1'b0;
        end else if (grant_alu) begin
            we_d   = !is_zero_reg(wb.alu_dst);
            addr_d = wb.alu_dst;
            data_d = wb.alu_data;
        end

        // A new issue to the register being retired keeps it busy.
        if (wb.issue_valid) busy_d[wb.issue_dst] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign wb.lsu_ready   = !full;
    assign wb.alu_stall   = stall_q;
    assign wb.write_reg   = we_q;
    assign wb.dstreg_addr = addr_q;
    assign wb.dstreg_data = data_q;
    assign wb.busy        = busy_q;

    a_no_alu_during_stall: assert property (@(posedge clk) disable iff (rst)
        !(stall_q && wb.alu_valid));

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized and directed bench for wb_arbiter against a queue model
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    wb_rec_t     mq[$];
    int          m_cnt;
    bit          m_stall;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cnt   = 0;
        m_stall = 0;
        m_we    = 0;
        m_addr  = '0;
        m_data  = '0;
        m_busy  = '0;
    endtask

    task automatic set_in(input bit av, input logic [4:0] ad, input logic [31:0] adat,
                          input bit lv, input logic [4:0] ld, input logic [31:0] ldat,
                          input bit iv, input logic [4:0] idst);
        bus.alu_valid   = av;
        bus.alu_dst     = ad;
        bus.alu_data    = adat;
        bus.lsu_valid   = lv;
        bus.lsu_dst     = ld;
        bus.lsu_data    = ldat;
        bus.issue_valid = iv;
        bus.issue_dst   = idst;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock of the model: pick a winner by the arbitration rules, then compare after the edge.
    task automatic cycle();
        int      sz;
        bit      pop_g, alu_g, next_stall;
        wb_rec_t e;
        sz = mq.size();
        chk("lsu_ready", bus.lsu_ready, sz < DEPTH);
        chk("alu_stall", bus.alu_stall, m_stall);
        pop_g = 0;
        alu_g = 0;
        if (m_stall && sz > 0)   pop_g = 1;
        else if (bus.alu_valid)  alu_g = 1;
        else if (sz > 0)         pop_g = 1;

        next_stall = 0;
        if (alu_g && sz > 0) begin
            if (m_cnt == STARVE_LIMIT - 1) begin
                next_stall = 1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0;
        end

        m_we = 0;
        if (pop_g) begin
            e = mq.pop_front();
            m_we   = (e.dst != 0);
            m_addr = e.dst;
            m_data = e.data;
            if (e.dst != 0) m_busy[e.dst] = 1'b0;
        end else if (alu_g) begin
            m_we   = (bus.alu_dst != 0);
            m_addr = bus.alu_dst;
            m_data = bus.alu_data;
        end
        if (bus.issue_valid) m_busy[bus.issue_dst] = 1'b1;
        m_busy[0] = 1'b0;
        if (bus.lsu_valid && sz < DEPTH) begin
            e.dst  = bus.lsu_dst;
            e.data = bus.lsu_data;
            mq.push_back(e);
        end
        m_stall = next_stall;

        @(posedge clk);
        #1;
        chk("write_reg", bus.write_reg, m_we);
        if (m_we) begin
            chk("dstreg_addr", bus.dstreg_addr, m_addr);
            chk("dstreg_data", bus.dstreg_data, m_data);
        end
        chk("busy", bus.busy, m_busy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_write_reg", bus.write_reg, 0);
        chk("rst_addr", bus.dstreg_addr, 0);
        chk("rst_data", bus.dstreg_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_lsu_ready", bus.lsu_ready, 1);
        chk("rst_alu_stall", bus.alu_stall, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;
        do_reset();

        // ALU result dst=5 written one cycle later, for one cycle only
        set_in(1, 5, 32'h1234, 0, 0, 0, 0, 0);
        cycle();
        chk("alu_we", bus.write_reg, 1);
        chk("alu_addr", bus.dstreg_addr, 5);
        chk("alu_data", bus.dstreg_data, 32'h1234);
        idle();
        cycle();
        chk("alu_we_drop", bus.write_reg, 0);

        // Issue r7, then LSU result for r7 two cycles later
        set_in(0, 0, 0, 0, 0, 0, 1, 7);
        cycle();
        chk("busy7_set", bus.busy[7], 1);
        idle();
        cycle();
        set_in(0, 0, 0, 1, 7, 32'hDEAD, 0, 0);
        cycle();
        chk("lsu_not_bypassed", bus.write_reg, 0);
        idle();
        cycle();
        chk("lsu_we", bus.write_reg, 1);
        chk("lsu_data", bus.dstreg_data, 32'hDEAD);
        chk("busy7_clr", bus.busy[7], 0);
        idle();
        cycle();

        // Fill FIFO under continuous ALU traffic until the starvation stall
        set_in(1, 3, 32'hA0, 1, 4, 32'hB0, 1, 4);
        cycle();
        set_in(1, 3, 32'hA1, 1, 6, 32'hB1, 1, 6);
        cycle();
        chk("full_ready", bus.lsu_ready, 0);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 3, 32'hA2 + i, 0, 0, 0, 0, 0);
            cycle();
        end
        chk("stall_pulse", bus.alu_stall, 1);
        idle();
        cycle();
        chk("stall_pop_addr", bus.dstreg_addr, 4);
        chk("stall_ready", bus.lsu_ready, 1);
        for (int i = 0; i < 3; i++) cycle();

        // x0 from both sources is consumed silently
        set_in(0, 0, 0, 1, 0, 32'h55, 0, 0);
        cycle();
        set_in(1, 0, 32'h66, 0, 0, 0, 0, 0);
        cycle();
        idle();
        cycle();
        chk("x0_lsu_we", bus.write_reg, 0);
        cycle();

        // Re-issue r9 on the cycle its earlier LSU result retires
        set_in(0, 0, 0, 0, 0, 0, 1, 9);
        cycle();
        set_in(0, 0, 0, 1, 9, 32'h99, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 1, 9);
        cycle();
        chk("busy9_kept", bus.busy[9], 1);
        chk("r9_written", bus.write_reg, 1);
        idle();
        cycle();

        // Reset with two queued entries and busy = r8|r9
        set_in(1, 2, 32'h1, 1, 8, 32'h8, 1, 8);
        cycle();
        set_in(1, 2, 32'h2, 1, 9, 32'h9, 1, 9);
        cycle();
        chk("pre_rst_busy", bus.busy, 32'h0000_0300);
        idle();
        do_reset();
        for (int i = 0; i < 4; i++) cycle();

        // Randomized traffic; ALU honours the model's stall
        for (int i = 0; i < 600; i++) begin
            set_in(m_stall ? 1'b0 : 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                   1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                   ($urandom_range(0, 3) == 0), 5'($urandom));
            cycle();
        end
        idle();
        for (int i = 0; i < 4; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writer side of the register-file write port (write_reg / dstreg_addr / dstreg_data).
- Merges two result sources onto the single port:
  - single-cycle ALU results, which have no backpressure;
  - long-latency load/store results, which use a valid/ready handshake and pass through a small FIFO.
- Keeps a busy scoreboard of registers with outstanding long-latency writes, so decode can stall on RAW hazards.
- Sits between execute/memory and the regfile in the core pipeline.

Parameters:
- DEPTH, 2, LSU result FIFO entries (power of two, at least 2).
- STARVE_LIMIT, 4, consecutive cycles the FIFO head may lose to the ALU before the ALU is stalled.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- alu_valid  in  1  ALU result present this cycle.
- alu_dst  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_stall  out  1  registered; while high, upstream must hold alu_valid=0.
- lsu_valid  in  1  LSU result offered.
- lsu_ready  out  1  FIFO can accept; equals !full (combinational from state only).
- lsu_dst  in  5  LSU destination register.
- lsu_data  in  32  LSU result.
- issue_valid  in  1  long-latency instruction issued this cycle.
- issue_dst  in  5  its destination register.
- busy  out  32  scoreboard; bit i set means register i has a pending LSU write.
- write_reg  out  1  regfile write enable (registered).
- dstreg_addr  out  5  regfile write address (registered).
- dstreg_data  out  32  regfile write data (registered).

Behaviour:
- Reset values (asynchronous, immediate):
  - write_reg=0, dstreg_addr=0, dstreg_data=0, alu_stall=0, busy=0.
  - FIFO empty, so lsu_ready=1. Starvation counter=0.
- LSU accept: lsu_valid && lsu_ready pushes {lsu_dst, lsu_data} at the posedge. No combinational path from lsu_valid to lsu_ready.
- Grant, evaluated each cycle:
  - alu_stall=1 and FIFO non-empty: pop FIFO. alu_valid is ignored (assertion flags it).
  - Otherwise, alu_valid=1: ALU wins.
  - Otherwise, FIFO non-empty: pop FIFO.
  - Otherwise: idle.
- Output registers:
  - The granted entry drives write_reg/dstreg_addr/dstreg_data on the next posedge.
  - ALU latency is 1 cycle (valid in N, write_reg in N+1).
  - LSU minimum latency is 2 cycles (accepted in N, earliest write_reg in N+2). No FIFO bypass.
  - With no grant, write_reg=0. dstreg_addr/dstreg_data hold their last values.
- x0: a granted entry with dst=0 is consumed but drives write_reg=0.
- Starvation counter:
  - Increments in each cycle where the FIFO is non-empty and the ALU is granted.
  - Clears on any FIFO pop, or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT-1 and the ALU is granted again, alu_stall=1 for exactly the next cycle, and the counter clears.
- FIFO full plus push plus pop in the same cycle: the pop frees a slot, but lsu_ready was already 0, so no push occurs.
- FIFO empty plus push: the entry is poppable from the next cycle onward.
- Scoreboard:
  - issue_valid sets busy[issue_dst].
  - An LSU entry popped with dst≠0 clears busy[dst] at the same posedge its write is registered.
  - Set and clear of the same bit in one cycle: set wins.
  - busy[0] is always 0. ALU grants never touch busy.
- Ordering: this block does not reorder or compare ALU and LSU writes to the same register. Upstream issue logic uses busy to prevent that hazard.
- Reset mid-operation: FIFO contents and all pending busy bits are discarded. No write is issued after rst deasserts until new input arrives.

Decomposition:
- Shared package/header (99_define.vh):
  - REG_ADDR_W=5, XLEN=32, REG_ZERO=5'b00000.
  - Result record layout: {dst, data}, 37 bits.
- One sub-module: wb_fifo.
  - Parameterised DEPTH×37, asynchronous active-high reset.
  - Ports: push, pop, full, empty, head.
- Arbitration, starvation counter, scoreboard and output registers live in the top.

Test Plan:
- Reset, then ALU result dst=5, data=0x1234 in cycle 1 -> write_reg=1, dstreg_addr=5, dstreg_data=0x1234 in cycle 2 only; lsu_ready=1 throughout.
- issue dst=7, then LSU result dst=7, data=0xDEAD accepted in cycle 3 with no ALU traffic -> busy[7]=1 from cycle 2; write in cycle 5; busy[7]=0 in cycle 5.
- Two LSU results accepted back-to-back (DEPTH=2) while alu_valid is held high -> lsu_ready=0 after the 2nd push. alu_stall pulses after 4 ALU grants; the FIFO head is written in the stall cycle+1 and lsu_ready returns to 1.
- LSU result with dst=0, and ALU result with dst=0 -> both consumed, write_reg stays 0, busy unchanged.
- issue_valid dst=9 in the same cycle an LSU entry dst=9 is popped -> busy[9] remains 1.
- Assert rst while the FIFO holds 2 entries and busy=0x00000300 -> outputs 0, busy=0, lsu_ready=1 immediately; no write follows after release.
